// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick scheduler: run/stop state encoding,
// default period width and channel-index width calculation.
package tick_sched_pkg;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam int unsigned PerWDefault = 16;

    // Channel index needs at least one bit even for a single channel.
    function automatic int unsigned chan_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_sched_if.sv
// Configuration port of the tick scheduler: valid/ready write of one
// channel's period register.
interface tick_sched_if
    import tick_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned PER_W  = PerWDefault
);

    localparam int unsigned ChanW = chan_w(NUM_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [ChanW-1:0] cfg_chan;
    logic [PER_W-1:0] cfg_period;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_period,
        output cfg_ready
    );

endinterface

// File: rtl/tick_chan.sv
// One rate channel: period register, base-tick counter, one-cycle strobe and
// a square wave that toggles on every strobe.
module tick_chan #(
    parameter int unsigned PER_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             base_tick,
    input  logic             wr,
    input  logic [PER_W-1:0] period,
    output logic             tick_out,
    output logic             tick_level
);

    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             level_q, level_d;
    logic             hit;

    assign hit        = (cnt_q == period_q - 1'b1);
    assign tick_out   = tick_q;
    assign tick_level = level_q;

    // A write restarts the channel; the period register survives clr.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        level_d  = level_q;
        if (wr) begin
            period_d = period;
            cnt_d    = '0;
            level_d  = 1'b0;
        end else if (clr || (period_q == '0)) begin
            cnt_d   = '0;
            level_d = 1'b0;
        end else if (base_tick) begin
            if (hit) begin
                cnt_d   = '0;
                tick_d  = 1'b1;
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            level_q  <= 1'b0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/tick_sched.sv
// Tick scheduler top: run/stop FSM, shared prescaler, config handshake and
// channel decode feeding NUM_CH tick_chan instances.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned PRE_DIV = 50_000,
    parameter int unsigned PER_W   = PerWDefault
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              run,
    tick_sched_if.slave       cfg,
    output logic [NUM_CH-1:0] tick_out,
    output logic [NUM_CH-1:0] tick_level,
    output logic              busy
);

    localparam int unsigned    PreW   = $clog2(PRE_DIV);
    localparam int unsigned    ChanW  = chan_w(NUM_CH);
    localparam logic [PreW-1:0] PreMax = PreW'(PRE_DIV - 1);

    state_e            state_q, state_d;
    logic [PreW-1:0]   presc_q, presc_d;
    logic              base_tick;
    logic              cfg_fire;
    logic              chan_clr;
    logic [NUM_CH-1:0] chan_wr;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (run)  state_d = StRun;
            StRun:   if (!run) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q == StRun);
    assign base_tick = busy && (presc_q == PreMax);
    // Blocking writes on base_tick keeps a write off any channel evaluation.
    assign cfg.cfg_ready = !base_tick;
    assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
    // Clearing on the stopping edge suppresses a strobe due in that cycle.
    assign chan_clr      = (state_d == StIdle);

    always_comb begin
        presc_d = '0;
        if (busy && run && !base_tick) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    // Indices at or above NUM_CH match nothing and are silently dropped.
    always_comb begin
        chan_wr = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            chan_wr[i] = cfg_fire && (cfg.cfg_chan == ChanW'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_chan
        tick_chan #(
            .PER_W (PER_W)
        ) u_chan (
            .clk_in     (clk_in),
            .rst_n      (rst_n),
            .clr        (chan_clr),
            .base_tick  (base_tick),
            .wr         (chan_wr[g]),
            .period     (cfg.cfg_period),
            .tick_out   (tick_out[g]),
            .tick_level (tick_level[g])
        );
    end

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched with PRE_DIV=4, PER_W=8, NUM_CH=4: expected
// strobes are queued when stimulus is applied and retired as the DUT strobes.
module tb_tick_sched;

    localparam int unsigned NumCh  = 4;
    localparam int unsigned PreDiv = 4;
    localparam int unsigned PerW   = 8;

    typedef struct {
        int ch;
        int cyc;
    } ev_t;

    logic             clk_in;
    logic             rst_n;
    logic             run;
    logic [NumCh-1:0] tick_out;
    logic [NumCh-1:0] tick_level;
    logic             busy;

    tick_sched_if #(.NUM_CH(NumCh), .PER_W(PerW)) cfg_if ();

    tick_sched #(
        .NUM_CH  (NumCh),
        .PRE_DIV (PreDiv),
        .PER_W   (PerW)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .run        (run),
        .cfg        (cfg_if),
        .tick_out   (tick_out),
        .tick_level (tick_level),
        .busy       (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int               tests = 0;
    int               fails = 0;
    int               cyc   = 0;
    ev_t              exp_q[$];
    logic [NumCh-1:0] lvl_exp = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_series(input int ch, input int first, input int step, input int last);
        for (int c = first; c <= last; c += step) exp_q.push_back('{ch: ch, cyc: c});
    endtask

    // Advance one clock, then score every channel's strobe and level.
    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
        for (int ch = 0; ch < NumCh; ch++) begin
            int idx;
            idx = -1;
            foreach (exp_q[j]) if (exp_q[j].ch == ch && exp_q[j].cyc == cyc) idx = j;
            chk($sformatf("strobe ch%0d cyc%0d", ch, cyc), 32'(tick_out[ch]), 32'(idx >= 0));
            if (idx >= 0) begin
                exp_q.delete(idx);
                lvl_exp[ch] = ~lvl_exp[ch];
            end
        end
        chk($sformatf("level cyc%0d", cyc), 32'(tick_level), 32'(lvl_exp));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_write(input int ch, input int per);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_chan   = 2'(ch);
        cfg_if.cfg_period = 8'(per);
        chk("cfg_ready idle", 32'(cfg_if.cfg_ready), 32'd1);
        lvl_exp[ch] = 1'b0;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        run               = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_chan   = '0;
        cfg_if.cfg_period = '0;
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("reset tick_out", 32'(tick_out), 32'd0);
        chk("reset tick_level", 32'(tick_level), 32'd0);
        ticks(2);
        rst_n = 1'b1;

        // Basic rates with ch2 left disabled, 100 cycles.
        cfg_write(0, 1);
        cfg_write(1, 3);
        run = 1'b1;
        cyc = -1;
        push_series(0, 4, 4, 96);
        push_series(1, 12, 12, 96);
        tick();
        chk("busy cycle 0", 32'(busy), 32'd1);
        ticks(99);
        chk("rates queue drained", 32'(exp_q.size()), 32'd0);

        // Stop: the ch0 strobe due in cycle 100 must not appear.
        run     = 1'b0;
        lvl_exp = '0;
        tick();
        chk("stop busy", 32'(busy), 32'd0);
        chk("stop tick_out", 32'(tick_out), 32'd0);
        chk("stop cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
        ticks(2);

        // Restart with retained periods.
        run = 1'b1;
        cyc = -1;
        push_series(0, 4, 4, 12);
        push_series(1, 12, 12, 12);
        ticks(13);
        chk("restart queue drained", 32'(exp_q.size()), 32'd0);
        run     = 1'b0;
        lvl_exp = '0;
        tick();

        // Mid-run reconfig of ch1 to period 1 at cycle 6.
        run = 1'b1;
        cyc = -1;
        push_series(0, 4, 4, 16);
        ticks(7);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_chan   = 2'd1;
        cfg_if.cfg_period = 8'd1;
        chk("cfg_ready presc2", 32'(cfg_if.cfg_ready), 32'd1);
        lvl_exp[1] = 1'b0;
        push_series(1, 8, 4, 16);
        tick();
        cfg_if.cfg_valid = 1'b0;
        ticks(9);
        chk("reconfig queue drained", 32'(exp_q.size()), 32'd0);

        // Collision: ch0 written at prescaler 2, ch3 held over prescaler 3.
        push_series(1, 20, 4, 32);
        ticks(2);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_chan   = 2'd0;
        cfg_if.cfg_period = 8'd2;
        chk("collision first ready", 32'(cfg_if.cfg_ready), 32'd1);
        lvl_exp[0] = 1'b0;
        push_series(0, 24, 8, 32);
        tick();
        cfg_if.cfg_chan   = 2'd3;
        cfg_if.cfg_period = 8'd1;
        chk("collision blocked ready", 32'(cfg_if.cfg_ready), 32'd0);
        tick();
        chk("collision retry ready", 32'(cfg_if.cfg_ready), 32'd1);
        lvl_exp[3] = 1'b0;
        push_series(3, 24, 4, 32);
        tick();
        cfg_if.cfg_valid = 1'b0;
        ticks(12);
        chk("collision queue drained", 32'(exp_q.size()), 32'd0);

        // Async reset between edges while running.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async tick_out", 32'(tick_out), 32'd0);
        chk("async tick_level", 32'(tick_level), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
        lvl_exp = '0;
        ticks(2);
        rst_n = 1'b1;
        cyc   = -1;
        tick();
        chk("post-reset busy", 32'(busy), 32'd1);
        ticks(40);
        chk("post-reset queue empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tick_sched.md
# tick_sched

Programmable tick scheduler that shares one prescaler among NUM_CH independent rate channels. Each channel produces a one-cycle enable strobe and a 50%-duty slow square wave at its own configured period. It replaces per-consumer free-running clock dividers: downstream logic stays on `clk_in` and uses the strobes as clock enables. A valid/ready port configures it, and a run/stop state machine sequences it.

## Interface
Parameters:
- NUM_CH, 4, number of tick channels (1..16)
- PRE_DIV, 50_000, shared prescaler divide; base tick = `clk_in` / PRE_DIV (>= 2)
- PER_W, 16, width of per-channel period, counted in base ticks

Ports:
- clk_in  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- run  in  1  level; 1 = schedule ticks, 0 = stop and clear counters
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept; transfer on `cfg_valid && cfg_ready`
- cfg_chan  in  $clog2(NUM_CH) (min 1)  target channel; out-of-range index is accepted and ignored
- cfg_period  in  PER_W  period in base ticks; 0 = channel disabled
- tick_out  out  NUM_CH  one-cycle strobe per channel
- tick_level  out  NUM_CH  square wave per channel; toggles at each strobe
- busy  out  1  1 while state is RUN

## Operation
- States: IDLE, RUN.
  - IDLE→RUN on the edge where `run` is sampled high.
  - RUN→IDLE on the edge where `run` is sampled low.
- IDLE behaviour:
  - prescaler = 0 and all channel counters = 0.
  - tick_out = 0 and tick_level = 0.
  - cfg_ready = 1.
- RUN behaviour:
  - Prescaler counts 0..PRE_DIV-1 and wraps to 0. base_tick is the condition prescaler == PRE_DIV-1.
  - On base_tick, each channel with period P ≥ 1 checks its counter:
    - counter == P-1: counter ← 0, tick_out[i] ← 1 for one cycle, tick_level[i] ← ~tick_level[i].
    - otherwise: counter ← counter + 1.
  - A channel with P = 0 holds counter = 0, tick_out = 0, tick_level = 0.
- Config:
  - An accepted write stores cfg_period in the channel's period register.
  - On that same edge, the channel's counter and tick_level are cleared to 0.
  - Config is legal in both states. Period registers persist across RUN→IDLE.
- Collision rule: in RUN, cfg_ready = 0 in the cycle where base_tick is true. This means a write never coincides with a channel evaluation. cfg_ready is combinational from state and prescaler.
- Counter width is PER_W. All period values 1..2^PER_W-1 are legal; no overflow is possible.

## Timing
- Reset (async assert; release is synchronised to clk_in):
  - state = IDLE, prescaler = 0.
  - All counters, periods, tick_out and tick_level = 0.
  - busy = 0, cfg_ready = 1.
- Cycle numbering: cycle 0 is the first cycle with busy = 1. In that cycle prescaler = 0.
- Channel with period P: tick_out[i] is high in cycles k·P·PRE_DIV, k = 1, 2, … Each pulse lasts exactly one cycle.
- tick_level[i] rises with the first strobe. Its period is 2·P·PRE_DIV.
- Reconfiguring channel i in RUN at cycle c: the next strobe is at the first cycle after c with prescaler == 0 and at least P base_ticks elapsed since c. Other channels are unaffected.
- run low sampled at edge e: from e onward, busy = 0 and all tick_out/tick_level = 0. A strobe already due in that cycle is suppressed.
- Async reset mid-RUN: outputs clear immediately without waiting for the clock. The state machine returns to IDLE, and period registers clear.
- Config latency: a write accepted at edge e takes effect from edge e.

## Structure
- Package `tick_sched_pkg`:
  - state enum {IDLE, RUN}
  - PER_W default
  - helper function for channel-index width (min 1)
- Sub-module `tick_chan`, instantiated NUM_CH times:
  - inputs: clk_in, rst_n, clr, base_tick, period
  - outputs: tick_out, tick_level
  - contents: counter, period register and strobe logic
- Top level contains the FSM, prescaler, cfg handshake and channel decode.

## Test plan
All scenarios use PRE_DIV = 4, PER_W = 8, NUM_CH = 4.
1. Basic rates: reset, cfg ch0 = 1, ch1 = 3, run = 1.
   - ch0 strobes at cycles 4, 8, 12.
   - ch1 strobes at cycles 12, 24.
   - tick_level[1] rises at 12 and falls at 24.
2. Disabled channel: ch2 period 0, run for 100 cycles → tick_out[2] = 0 and tick_level[2] = 0 throughout.
3. Collision: cfg_valid held high from a cycle with prescaler == 2.
   - Accepted at prescaler == 2.
   - A second request presented at prescaler == 3 sees cfg_ready = 0 and is accepted one cycle later.
   - Only the targeted channel's counter resets.
4. Mid-run reconfig: ch1 = 3 running, write ch1 = 1 at cycle 6 → next ch1 strobe at cycle 8. ch0 timing is unchanged.
5. Stop/restart: run = 0 at cycle 10.
   - busy and all outputs are 0 from cycle 10.
   - run = 1 again → ch0 strobes 4 cycles after re-entry, with periods retained.
6. Async reset: assert rst_n = 0 between clock edges mid-RUN.
   - Outputs clear immediately.
   - After release, no strobes occur even with run = 1, because periods are cleared.
